mgt01_ctx_reg_file: RTL
=======================

# mgt01_ctx_reg_file

Parametrised integer register file for MicroGT-01 with a configurable number of combinational read ports and one write port. It adds a built-in context engine that streams the register file out (save) or in (restore) one word per beat over a valid/ready handshake. This replaces wide parallel dump/load buses for interrupt entry and exit. It sits in the decode/writeback stage and connects to the interrupt controller's context-stack interface.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers, ≥2; AW = $clog2(DEPTH) is derived
- RD_PORTS, 2, number of read ports, ≥1
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written and skipped by the context engine
- clk_i  in  1  single clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- clk_en_i  in  1  gates the core write port only
- rd_addr_i  in  RD_PORTS*AW  packed read addresses; port p uses bits [p*AW +: AW]
- rd_data_o  out  RD_PORTS*DATA_W  packed read data
- we_i  in  1  core write enable
- wr_addr_i  in  AW  core write address
- wr_data_i  in  DATA_W  core write data
- save_req_i  in  1  start a context save (level-sampled in IDLE)
- restore_req_i  in  1  start a context restore (level-sampled in IDLE)
- busy_o  out  1  context engine active (SAVE or RESTORE)
- done_o  out  1  one-cycle pulse when a save or restore completes
- sv_valid_o / sv_ready_i  out/in  1  save stream handshake
- sv_data_o  out  DATA_W  saved register value
- sv_addr_o  out  AW  index of the register in sv_data_o
- rs_valid_i / rs_ready_o  in/out  1  restore stream handshake
- rs_data_i  in  DATA_W  register value to restore

## Operation
- Reads are combinational. Address 0 with ZERO_REG=1 returns 0. An address ≥ DEPTH returns 0.
- A core write happens at the clock edge when we_i & clk_en_i & !busy_o & !(ZERO_REG & wr_addr_i==0) & wr_addr_i<DEPTH.
- While busy_o is high, core writes are dropped silently. Reads stay functional.
- FSM states: IDLE, SAVE, RESTORE, DONE. FIRST = ZERO_REG ? 1 : 0 and LAST = DEPTH-1.
- IDLE: if save_req_i, go to SAVE with idx←FIRST. Else if restore_req_i, go to RESTORE with idx←FIRST. Save wins if both are high.
- SAVE:
  - sv_valid_o=1, sv_addr_o=idx, sv_data_o=reg[idx].
  - On sv_valid_o & sv_ready_i: if idx==LAST, go to DONE; else idx++.
- RESTORE:
  - rs_ready_o=1.
  - On rs_valid_i & rs_ready_o: reg[idx]←rs_data_i; if idx==LAST, go to DONE; else idx++.
- DONE: done_o=1 for exactly one cycle, then return to IDLE. A request held high re-triggers a new transfer from IDLE.
- Requests arriving in SAVE, RESTORE or DONE are ignored.
- The engine ignores clk_en_i.
- The idx counter never wraps: termination is by the LAST compare.

## Timing
- Reset values (asynchronous): all registers 0, FSM in IDLE, idx=0. Outputs busy_o, done_o, sv_valid_o and rs_ready_o are 0; sv_addr_o and sv_data_o are 0.
- Reset asserted mid-transfer aborts immediately. No done_o pulse is produced.
- Request sampled at edge N: busy_o and the first sv_valid_o/rs_ready_o are high from cycle N+1.
- Full throughput is one word per cycle. A save or restore with continuous handshake takes DEPTH-FIRST beats. done_o rises the cycle after the last beat, and busy_o falls in that same cycle.
- Save stream: once sv_valid_o is high, sv_data_o and sv_addr_o hold stable until accepted. No core write can disturb them, because writes are blocked while busy.
- Write-to-read in the same cycle: the read returns the old value unless RF_BYPASS_EN is defined.

## Configuration
- RF_BYPASS_EN defined: for every read port, if the core write qualifies this cycle and wr_addr_i equals rd_addr, rd_data_o returns wr_data_i combinationally. The zero register is never bypassed, and no bypass occurs while busy.
- RF_BYPASS_EN undefined: reads always return array contents. The written value is visible from the cycle after the edge.

## Test plan
- Reset, then read all addresses on both ports: all return 0. Write 0xDEADBEEF to r0: r0 still reads 0.
- Write 0x1234_5678 to r5 with clk_en_i=0: r5 stays 0. Repeat with clk_en_i=1: r5 reads 0x1234_5678 the next cycle. In the same write cycle, r5 reads 0x1234_5678 only when RF_BYPASS_EN is defined.
- Load reg[i]=i*0x11, then save with sv_ready_i randomly toggled: 31 beats, addresses 1..31 in order, each beat carrying the matching data. done_o pulses once and busy_o drops in the same cycle.
- Restore 31 words 0xA000_0000+i with rs_valid_i gaps, while core writes are attempted during the restore: final reg[i]=0xA000_0000+i and the core writes are lost.
- Assert save_req_i and restore_req_i together: a save runs. Assert restore_req_i during the save: it is ignored.
- Assert rst_n_i low at beat 10 of a save: all outputs go to 0 immediately, all registers read 0, and no done_o pulse is produced.

Source files
------------

// File: rtl/mgt01_ctx_reg_file_if.sv
// Context-stream bundle between the register file (slave) and the interrupt controller (master).
// Carries the save/restore requests, status, and the two valid/ready word streams.
interface mgt01_ctx_reg_file_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5
);
    logic              save_req_i;
    logic              restore_req_i;
    logic              busy_o;
    logic              done_o;
    logic              sv_valid_o;
    logic              sv_ready_i;
    logic [DATA_W-1:0] sv_data_o;
    logic [AW-1:0]     sv_addr_o;
    logic              rs_valid_i;
    logic              rs_ready_o;
    logic [DATA_W-1:0] rs_data_i;

    modport slave (
        input  save_req_i,
        input  restore_req_i,
        output busy_o,
        output done_o,
        output sv_valid_o,
        input  sv_ready_i,
        output sv_data_o,
        output sv_addr_o,
        input  rs_valid_i,
        output rs_ready_o,
        input  rs_data_i
    );

    modport master (
        output save_req_i,
        output restore_req_i,
        input  busy_o,
        input  done_o,
        input  sv_valid_o,
        output sv_ready_i,
        input  sv_data_o,
        input  sv_addr_o,
        output rs_valid_i,
        input  rs_ready_o,
        output rs_data_i
    );
endinterface

// File: rtl/mgt01_ctx_reg_file.sv
// Register file with combinational read ports, one write port and a save/restore stream engine.
// Define RF_BYPASS_EN to forward a qualifying core write to same-cycle reads.
module mgt01_ctx_reg_file #(
    parameter int unsigned  DATA_W   = 32,
    parameter int unsigned  DEPTH    = 32,
    parameter int unsigned  RD_PORTS = 2,
    parameter bit           ZERO_REG = 1'b1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       clk_en_i,
    input  logic [RD_PORTS*AW-1:0]     rd_addr_i,
    output logic [RD_PORTS*DATA_W-1:0] rd_data_o,
    input  logic                       we_i,
    input  logic [AW-1:0]              wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    mgt01_ctx_reg_file_if.slave        ctx
);

    typedef enum logic [1:0] {StIdle, StSave, StRestore, StDone} state_e;

    localparam logic [AW-1:0] First = ZERO_REG ? AW'(1) : '0;
    localparam logic [AW-1:0] Last  = AW'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              busy;
    logic              sv_fire;
    logic              rs_fire;
    logic              core_we;

    assign busy    = (state_q == StSave) || (state_q == StRestore);
    assign sv_fire = (state_q == StSave) && ctx.sv_ready_i;
    assign rs_fire = (state_q == StRestore) && ctx.rs_valid_i;
    assign core_we = we_i && clk_en_i && !busy && !(ZERO_REG && (wr_addr_i == '0))
                     && (32'(wr_addr_i) < DEPTH);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Termination is by the Last compare, so idx never wraps.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (ctx.save_req_i) begin
                    state_d = StSave;
                    idx_d   = First;
                end else if (ctx.restore_req_i) begin
                    state_d = StRestore;
                    idx_d   = First;
                end
            end
            StSave: begin
                if (sv_fire) begin
                    if (idx_q == Last) state_d = StDone;
                    else               idx_d   = idx_q + AW'(1);
                end
            end
            StRestore: begin
                if (rs_fire) begin
                    if (idx_q == Last) state_d = StDone;
                    else               idx_d   = idx_q + AW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ctx.busy_o     = 1'b0;
        ctx.done_o     = 1'b0;
        ctx.sv_valid_o = 1'b0;
        ctx.sv_addr_o  = '0;
        ctx.sv_data_o  = '0;
        ctx.rs_ready_o = 1'b0;
        unique case (state_q)
            StSave: begin
                ctx.busy_o     = 1'b1;
                ctx.sv_valid_o = 1'b1;
                ctx.sv_addr_o  = idx_q;
                ctx.sv_data_o  = regs_q[idx_q];
            end
            StRestore: begin
                ctx.busy_o     = 1'b1;
                ctx.rs_ready_o = 1'b1;
            end
            StDone:  ctx.done_o = 1'b1;
            default: ;
        endcase
    end

    // Core writes are blocked while busy, so the two write sources never collide.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (rs_fire) begin
            regs_q[idx_q] <= ctx.rs_data_i;
        end else if (core_we) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr_i[p*AW +: AW];

        always_comb begin
            data = '0;
            if (!(ZERO_REG && (addr == '0)) && (32'(addr) < DEPTH)) data = regs_q[addr];
`ifdef RF_BYPASS_EN
            // core_we already excludes the zero register and busy cycles.
            if (core_we && (wr_addr_i == addr)) data = wr_data_i;
`endif
        end

        assign rd_data_o[p*DATA_W +: DATA_W] = data;
    end

endmodule
